// File: rtl/sumador_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width and FSM encodings.
package sumador_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUMA = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sumador.sv
// 4-bit combinational ripple-carry adder, one full adder per bit.
module sumador
    import sumador_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                c_i,
    output logic [NIBBLE_W-1:0] s_o,
    output logic                c_o
);

    logic [NIBBLE_W:0] c;

    assign c[0] = c_i;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign c_o = c[NIBBLE_W];

endmodule

// File: rtl/sumador_serie.sv
// Nibble-serial WIDTH-bit adder: latches operands, adds one nibble per cycle
// through a single 4-bit adder, and holds the result until the consumer takes it.
module sumador_serie
    import sumador_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             carry_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] S_o,
    output logic             carry_o,
    output logic             busy_o
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; the producer holds its data until then. Operands transfer when
    // valid_i & ready_o, results when valid_o & ready_i.

    localparam int NIB  = WIDTH / NIBBLE_W;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              c_q, c_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              co_q, co_d;

    logic [IDXW+1:0]     sh;
    logic [WIDTH-1:0]    a_shift, b_shift;
    logic [NIBBLE_W-1:0] nib_s;
    logic                nib_co;

    // Bit offset of the active nibble is idx*4, i.e. idx with two zero LSBs.
    assign sh      = {idx_q, 2'b00};
    assign a_shift = a_q >> sh;
    assign b_shift = b_q >> sh;

    sumador u_sumador (
        .a_i (a_shift[NIBBLE_W-1:0]),
        .b_i (b_shift[NIBBLE_W-1:0]),
        .c_i (c_q),
        .s_o (nib_s),
        .c_o (nib_co)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            s_q     <= s_d;
            co_q    <= co_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        s_d     = s_q;
        co_d    = co_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    a_d     = A_i;
                    b_d     = B_i;
                    c_d     = carry_i;
                    s_d     = '0;
                    co_d    = 1'b0;
                    idx_d   = '0;
                    state_d = SUMA;
                end
            end
            SUMA: begin
                s_d = (s_q & ~(WIDTH'(4'hF) << sh)) | (WIDTH'(nib_s) << sh);
                c_d = nib_co;
                if (idx_q == LAST) begin
                    co_d    = nib_co;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (ready_i) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        ready_o = (state_q == IDLE);
        busy_o  = (state_q == SUMA);
        valid_o = (state_q == DONE);
    end

    assign S_o     = s_q;
    assign carry_o = co_q;

endmodule

// File: tb/tb_sumador_serie.sv
// Directed bench for sumador_serie (WIDTH=16): vector table, backpressure,
// async reset mid-operation and back-to-back streaming.
module tb_sumador_serie;

    localparam int W = 16;

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] A_i;
    logic [W-1:0] B_i;
    logic         carry_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] S_o;
    logic         carry_o;
    logic         busy_o;

    int errors = 0;
    int checks = 0;

    logic [W:0] exp_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         cout;
    } vec_t;

    vec_t vecs[8];

    sumador_serie #(.WIDTH(W)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .A_i     (A_i),
        .B_i     (B_i),
        .carry_i (carry_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .S_o     (S_o),
        .carry_o (carry_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge with the DUT idle; returns with valid_o high
    // (or the cycle budget exhausted) and the result not yet released.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         output int lat);
        A_i     = a;
        B_i     = b;
        carry_i = c;
        valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        A_i     = W'($urandom);
        B_i     = W'($urandom);
        carry_i = 1'($urandom_range(0, 1));
        chk("suma_ready", 32'(ready_o), 32'd0);
        chk("suma_busy", 32'(busy_o), 32'd1);
        lat = 0;
        while (!valid_o && lat < 20) begin
            @(posedge clk_i); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int n_acc;
        int n_got;
        int cyc;
        int acc_cyc[2];
        logic acc;
        logic [W:0] e;
        logic [W-1:0] held_s;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[3] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[5] = '{16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0};
        vecs[6] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0};
        vecs[7] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};

        rst_n_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        A_i     = '0;
        B_i     = '0;
        carry_i = 1'b0;
        #12;
        chk("rst_S", 32'(S_o), 32'h0);
        chk("rst_carry", 32'(carry_o), 32'h0);
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        chk("rst_ready", 32'(ready_o), 32'h1);

        // Table of directed vectors, consumer always ready.
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd4);
            chk($sformatf("vec%0d_S", i), 32'(S_o), 32'(vecs[i].s));
            chk($sformatf("vec%0d_carry", i), 32'(carry_o), 32'(vecs[i].cout));
            @(posedge clk_i); #1;
            chk($sformatf("vec%0d_idle", i), 32'({ready_o, valid_o}), 32'b10);
        end

        // Backpressure: result must hold while ready_i is low.
        ready_i = 1'b0;
        do_op(16'h0F0F, 16'h00F1, 1'b0, lat);
        chk("bp_lat", 32'(lat), 32'd4);
        held_s = 16'h1000;
        for (int i = 0; i < 6; i++) begin
            valid_i = 1'($urandom_range(0, 1));
            A_i     = W'($urandom);
            B_i     = W'($urandom);
            @(posedge clk_i); #1;
            chk($sformatf("bp%0d_valid", i), 32'(valid_o), 32'd1);
            chk($sformatf("bp%0d_S", i), 32'(S_o), 32'(held_s));
            chk($sformatf("bp%0d_ready", i), 32'(ready_o), 32'd0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        chk("bp_release", 32'({ready_o, valid_o}), 32'b10);

        // Asynchronous reset after two nibbles of 0x0088+0x0088.
        A_i     = 16'h0088;
        B_i     = 16'h0088;
        carry_i = 1'b0;
        valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        chk("mid_S", 32'(S_o), 32'h0010);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("arst_S", 32'(S_o), 32'h0);
        chk("arst_busy", 32'(busy_o), 32'h0);
        chk("arst_valid", 32'(valid_o), 32'h0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        chk("arst_ready", 32'(ready_o), 32'h1);
        do_op(16'h0001, 16'h0001, 1'b0, lat);
        chk("post_rst_S", 32'(S_o), 32'h0002);
        chk("post_rst_carry", 32'(carry_o), 32'h0);
        @(posedge clk_i); #1;

        // Back-to-back stream, scoreboard against A+B+cin.
        n_acc = 0;
        n_got = 0;
        cyc   = 0;
        A_i     = 16'h1234;
        B_i     = 16'h4321;
        carry_i = 1'b0;
        valid_i = 1'b1;
        ready_i = 1'b1;
        while (n_got < 2 && cyc < 40) begin
            @(negedge clk_i);
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("b2b_unexpected", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("b2b%0d_S", n_got), 32'(S_o), 32'(e[W-1:0]));
                    chk($sformatf("b2b%0d_carry", n_got), 32'(carry_o), 32'(e[W]));
                end
                n_got++;
            end
            acc = valid_i && ready_o;
            if (acc) begin
                exp_q.push_back((W+1)'(A_i) + (W+1)'(B_i) + (W+1)'(carry_i));
                acc_cyc[n_acc] = cyc;
            end
            @(posedge clk_i); #1;
            if (acc) begin
                n_acc++;
                if (n_acc == 1) begin
                    A_i = 16'hFFFF;
                    B_i = 16'h0001;
                end else begin
                    valid_i = 1'b0;
                end
            end
            cyc++;
        end
        chk("b2b_done", 32'(n_got), 32'd2);
        if (n_acc == 2) chk("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
        else chk("b2b_accepts", 32'(n_acc), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
